led_mode_arbiter: RTL and testbench



---
 rtl/led_mode_arbiter.sv | 160 ++++++++++++++++
 tb/tb_led_mode_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_arbiter.sv
// led_mode_arbiter: shares the LED_DRIVER mode input between the alarm,
// heating and cooling requesters. Fixed priority alarm > heat > cool, a
// minimum hold time against flicker, and a drain delay that keeps the last
// mode on screen for a short time after every request has gone away.
//
// The owner register doubles as the LED output: it holds the displayed mode
// in HOLD, ACTIVE and DRAIN and is cleared to OFF in the OFF state.

module led_mode_arbiter #(
    parameter int CNT_W      = 16,
    parameter int MIN_HOLD   = 100,
    parameter int IDLE_DELAY = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_alarm,
    input  logic       req_heat,
    input  logic       req_cool,
    output logic [1:0] LED,
    output logic       gnt_alarm,
    output logic       gnt_heat,
    output logic       gnt_cool,
    output logic       mode_chg
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_HOLD,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_HEAT  = 2'b01;
    localparam logic [1:0] MODE_COOL  = 2'b10;
    localparam logic [1:0] MODE_ALARM = 2'b11;

    // HOLD hands over to ACTIVE one edge before the hold time ends, so the
    // ACTIVE re-evaluation lands exactly MIN_HOLD edges after the grant.
    // A hold of one cycle cannot be shorter than a single HOLD cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST  = (MIN_HOLD >= 2) ? CNT_W'(MIN_HOLD - 2) : '0;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(IDLE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       owner;
    logic [1:0]       owner_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       winner;
    logic             grant_nxt;

    // Fixed-priority pick of the requester that would win right now.
    always_comb begin
        winner = MODE_OFF;
        if (req_alarm) begin
            winner = MODE_ALARM;
        end else if (req_heat) begin
            winner = MODE_HEAT;
        end else if (req_cool) begin
            winner = MODE_COOL;
        end
    end

    // Next state, next owner and dwell counter update.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        unique case (state)
            ST_OFF: begin
                cnt_nxt   = '0;
                owner_nxt = MODE_OFF;
                if (winner != MODE_OFF) begin
                    owner_nxt = winner;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (req_alarm && (owner != MODE_ALARM)) begin
                    owner_nxt = MODE_ALARM;
                    cnt_nxt   = '0;
                end else if (cnt >= HOLD_LAST) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                cnt_nxt = '0;
                if (winner == MODE_OFF) begin
                    state_nxt = ST_DRAIN;
                end else if (winner != owner) begin
                    owner_nxt = winner;
                    state_nxt = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (winner != MODE_OFF) begin
                    cnt_nxt = '0;
                    if (winner == owner) begin
                        state_nxt = ST_ACTIVE;
                    end else begin
                        owner_nxt = winner;
                        state_nxt = ST_HOLD;
                    end
                end else if (cnt >= DRAIN_LAST) begin
                    owner_nxt = MODE_OFF;
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                owner_nxt = MODE_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Grants are only visible while the owner actually holds the display.
    always_comb begin
        grant_nxt = (state_nxt == ST_HOLD) || (state_nxt == ST_ACTIVE);
    end

    // State, owner and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            owner <= MODE_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered grant lines and the mode-change pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_alarm <= 1'b0;
            gnt_heat  <= 1'b0;
            gnt_cool  <= 1'b0;
            mode_chg  <= 1'b0;
        end else begin
            gnt_alarm <= grant_nxt && (owner_nxt == MODE_ALARM);
            gnt_heat  <= grant_nxt && (owner_nxt == MODE_HEAT);
            gnt_cool  <= grant_nxt && (owner_nxt == MODE_COOL);
            mode_chg  <= (owner_nxt != owner);
        end
    end

    assign LED = owner;

endmodule

// File: tb/tb_led_mode_arbiter.sv
// Testbench for led_mode_arbiter: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.

module tb_led_mode_arbiter;

    localparam int CNT_W      = 16;
    localparam int MIN_HOLD   = 8;
    localparam int IDLE_DELAY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_alarm = 1'b1;
    logic       req_heat  = 1'b1;
    logic       req_cool  = 1'b1;
    logic [1:0] LED;
    logic       gnt_alarm;
    logic       gnt_heat;
    logic       gnt_cool;
    logic       mode_chg;

    int n_cmp = 0;
    int n_mis = 0;
    bit cmp_en = 1'b0;

    // Model: displayed mode, cycles it has been displayed since its grant
    // (capped at MIN_HOLD), whether it is draining and for how long.
    int m_led   = 0;
    int m_age   = 0;
    bit m_drain = 1'b0;
    int m_dcnt  = 0;
    bit m_chg   = 1'b0;
    int m_win;
    int m_prev;

    led_mode_arbiter #(
        .CNT_W(CNT_W),
        .MIN_HOLD(MIN_HOLD),
        .IDLE_DELAY(IDLE_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_alarm(req_alarm),
        .req_heat(req_heat),
        .req_cool(req_cool),
        .LED(LED),
        .gnt_alarm(gnt_alarm),
        .gnt_heat(gnt_heat),
        .gnt_cool(gnt_cool),
        .mode_chg(mode_chg)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [3:0] onehot(input int mode);
        case (mode)
            3:       onehot = 4'b0100;
            1:       onehot = 4'b0010;
            2:       onehot = 4'b0001;
            default: onehot = 4'b0000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_mis++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input int e_led, input logic [3:0] e_gnt, input logic e_chg);
        checkOutput({name, "_led"}, {2'b00, LED}, 4'(e_led));
        checkOutput({name, "_gnt"}, {1'b0, gnt_alarm, gnt_heat, gnt_cool}, e_gnt);
        checkOutput({name, "_chg"}, {3'b000, mode_chg}, {3'b000, e_chg});
    endtask

    task automatic applyStimulus(input logic a, input logic h, input logic c);
        req_alarm = a;
        req_heat  = h;
        req_cool  = c;
    endtask

    // Behavioural model: a granted mode is locked until it has been shown
    // for MIN_HOLD cycles (only alarm may cut in), then follows the winner;
    // with no request it lingers IDLE_DELAY cycles before going dark.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_led   = 0;
            m_age   = 0;
            m_drain = 1'b0;
            m_dcnt  = 0;
            m_chg   = 1'b0;
        end else begin
            m_prev = m_led;
            m_win  = req_alarm ? 3 : (req_heat ? 1 : (req_cool ? 2 : 0));
            if (m_led == 0) begin
                if (m_win != 0) begin
                    m_led = m_win; m_age = 1; m_drain = 1'b0;
                end
            end else if (m_drain) begin
                if (m_win == m_led) begin
                    m_drain = 1'b0; m_age = MIN_HOLD;
                end else if (m_win != 0) begin
                    m_led = m_win; m_age = 1; m_drain = 1'b0;
                end else begin
                    m_dcnt++;
                    if (m_dcnt == IDLE_DELAY) begin
                        m_led = 0; m_drain = 1'b0;
                    end
                end
            end else if (m_age < MIN_HOLD) begin
                if (req_alarm && m_led != 3) begin
                    m_led = 3; m_age = 1;
                end else begin
                    m_age++;
                end
            end else begin
                if (m_win == 0) begin
                    m_drain = 1'b1; m_dcnt = 0;
                end else if (m_win != m_led) begin
                    m_led = m_win; m_age = 1;
                end
            end
            m_chg = (m_led != m_prev);
        end
    end

    // Compare DUT against the model midway through every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_led", {2'b00, LED}, 4'(m_led));
            checkOutput("model_gnt", {1'b0, gnt_alarm, gnt_heat, gnt_cool},
                        (m_led != 0 && !m_drain) ? onehot(m_led) : 4'b0000);
            checkOutput("model_chg", {3'b000, mode_chg}, {3'b000, m_chg});
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int r;
        #1 rst = 1'b1;
        @(negedge clk);
        checkAll("reset", 0, 4'b0000, 1'b0);
        @(negedge clk);
        checkAll("reset_hold", 0, 4'b0000, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_led", {2'b00, LED}, 4'h0);
        end

        // Heat grant, then cool waits out the hold time.
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkAll("grant", 1, 4'b0010, 1'b1);
        @(negedge clk);
        checkAll("grant_next", 1, 4'b0010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        checkAll("hold_last", 1, 4'b0010, 1'b0);
        @(negedge clk);
        checkAll("hold_switch", 2, 4'b0001, 1'b1);

        // Cool goes active, then every request drops.
        repeat (8) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkAll("drain_start", 2, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        checkAll("drain_last", 2, 4'b0000, 1'b0);
        @(negedge clk);
        checkAll("drain_expire", 0, 4'b0000, 1'b1);
        @(negedge clk);
        checkAll("drain_off", 0, 4'b0000, 1'b0);

        // Same mode returns during drain.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkAll("regrant_drain", 2, 4'b0000, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkAll("regrant", 2, 4'b0001, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        checkAll("regrant_off", 0, 4'b0000, 1'b0);

        // Alarm preempts heat in the middle of its hold.
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkAll("preempt", 3, 4'b0100, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        checkAll("preempt_hold", 3, 4'b0100, 1'b0);
        @(negedge clk);
        checkAll("preempt_back", 1, 4'b0010, 1'b1);

        // Asynchronous reset in the middle of a hold.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkAll("async_rst", 0, 4'b0000, 1'b0);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkAll("after_rst", 3, 4'b0100, 1'b1);

        // Randomized traffic with long quiet stretches and rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 999);
            if (r < 120) begin
                applyStimulus(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
            end else if (r < 170) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
            end else if (r >= 997) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
